// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIF FFT sequencer.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    UNLOAD,
    DONE
  } seq_state_t;

  localparam int DEF_RD_LATENCY = 1;
  localparam int DEF_BF_LATENCY = 2;
  localparam int PIPE_DEPTH = DEF_RD_LATENCY + DEF_BF_LATENCY;

  // Reverse the low log2n bits of addr (log2n <= 16).
  function automatic logic [15:0] bitrev(
    input logic [15:0] addr,
    input int          log2n
  );
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < log2n) r[i] = addr[log2n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// clk_en-gated shift register with asynchronous clear.
module fft_delay_line
  import fft_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_sr
      logic [WIDTH-1:0] sr [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (clk_en) begin
          sr[0] <= d;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIF FFT control sequencer: stage/butterfly walk, write-back pipe.
// Define FFT_SEQ_UNLOAD_EN to add a bit-reversed unload read pass after the last stage.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N      = 10,
  parameter int RD_LATENCY = 1,
  parameter int BF_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             bf_valid,
  input  logic             bf_ovalid,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic             err
);

  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int PIPE = RD_LATENCY + BF_LATENCY;
  localparam int CW   = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam int WPW  = 1 + 2 * LOG2N;

  localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
  localparam logic [LOG2N-1:0] K_HALF = LOG2N'(HALF - 1);
  localparam logic [LOG2N-1:0] K_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
  localparam logic [CW-1:0]    D_LAST = CW'(PIPE - 1);

  seq_state_t       state, state_n;
  logic [LOG2N-1:0] s, s_n;
  logic [LOG2N-1:0] k, k_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             err_q, err_n;

  logic             run_rd, unl_rd;
  logic [LOG2N-1:0] sh, span, j, g, bf_a;
  logic [WPW-1:0]   wp_d, wp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= '0;
      k     <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (clk_en) begin
      state <= state_n;
      s     <= s_n;
      k     <= k_n;
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    k_n     = k;
    cnt_n   = cnt;
    err_n   = err_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          s_n     = '0;
          k_n     = '0;
          cnt_n   = '0;
          err_n   = 1'b0;
        end
      end
      RUN: begin
        if (k == K_HALF) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else begin
          k_n = k + 1'b1;
        end
      end
      DRAIN: begin
        // Stage barrier: next stage reads data this stage is still writing.
        if (cnt == D_LAST) begin
          cnt_n = '0;
          k_n   = '0;
          if (s != S_LAST) begin
            state_n = RUN;
            s_n     = s + 1'b1;
          end else begin
`ifdef FFT_SEQ_UNLOAD_EN
            state_n = UNLOAD;
`else
            state_n = DONE;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      UNLOAD: begin
        if (k == K_LAST) state_n = DONE;
        else k_n = k + 1'b1;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (wr_en != bf_ovalid) err_n = 1'b1;
  end

  assign run_rd = (state == RUN);
  assign unl_rd = (state == UNLOAD);
  assign rd_en  = run_rd | unl_rd;
  assign busy   = run_rd | unl_rd | (state == DRAIN);
  assign done   = (state == DONE);
  assign stage  = s;
  assign err    = err_q;

  // span = 2^sh; group base = g * 2 * span built by shifting.
  always_comb begin
    sh   = S_LAST - s;
    span = ONE << sh;
    j    = k & (span - ONE);
    g    = k >> sh;
    bf_a = ((g << sh) << 1) | j;
    rd_addr_a = '0;
    rd_addr_b = '0;
    tw_addr   = '0;
    if (run_rd) begin
      rd_addr_a = bf_a;
      rd_addr_b = bf_a + span;
      tw_addr   = (LOG2N-1)'(j << s);
    end else if (unl_rd) begin
      rd_addr_a = LOG2N'(bitrev(16'(k), LOG2N));
    end
  end

  // Unload reads never enter the write pipe.
  assign wp_d = run_rd ? {1'b1, rd_addr_a, rd_addr_b} : '0;

  fft_delay_line #(
    .WIDTH(1),
    .DEPTH(RD_LATENCY)
  ) u_bf_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_en(clk_en),
    .d     (run_rd),
    .q     (bf_valid)
  );

  fft_delay_line #(
    .WIDTH(WPW),
    .DEPTH(PIPE)
  ) u_wr_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_en(clk_en),
    .d     (wp_d),
    .q     (wp_q)
  );

  assign wr_en     = wp_q[WPW-1];
  assign wr_addr_a = wp_q[2*LOG2N-1:LOG2N];
  assign wr_addr_b = wp_q[LOG2N-1:0];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer at LOG2N=3: schedule-table reference model, random clk_en/start.
// Honours FFT_SEQ_UNLOAD_EN the same way the design does.
module tb_fft_stage_sequencer;

  localparam int L    = 3;
  localparam int N    = 1 << L;
  localparam int RD   = 1;
  localparam int BF   = 2;
  localparam int P    = RD + BF;
  localparam int MAXC = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_en = 1'b0;
  logic         start = 1'b0;
  logic         bf_ovalid = 1'b0;
  logic         busy, done, rd_en, bf_valid, wr_en, err;
  logic [L-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [L-2:0] tw_addr;

  int vectors = 0;
  int miscompares = 0;

  logic         exp_rd   [MAXC];
  logic         exp_bfv  [MAXC];
  logic         exp_wr   [MAXC];
  logic         exp_busy [MAXC];
  logic         exp_done [MAXC];
  logic [L-1:0] exp_a    [MAXC];
  logic [L-1:0] exp_b    [MAXC];
  logic [L-2:0] exp_tw   [MAXC];
  logic [L-1:0] exp_stg  [MAXC];
  logic [L-1:0] exp_wa   [MAXC];
  logic [L-1:0] exp_wb   [MAXC];
  int           done_cyc;

  always #5 clk = ~clk;

  fft_stage_sequencer #(
    .LOG2N(L),
    .RD_LATENCY(RD),
    .BF_LATENCY(BF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr  (tw_addr),
    .bf_valid (bf_valid),
    .bf_ovalid(bf_ovalid),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b),
    .err      (err)
  );

  // Expected per-enabled-cycle schedule; cycle 0 is the start cycle.
  task automatic build_model();
    int t, span, j, g, a, r;
    for (int c = 0; c < MAXC; c++) begin
      exp_rd[c] = 0; exp_bfv[c] = 0; exp_wr[c] = 0;
      exp_busy[c] = 0; exp_done[c] = 0;
      exp_a[c] = '0; exp_b[c] = '0; exp_tw[c] = '0;
      exp_stg[c] = '0; exp_wa[c] = '0; exp_wb[c] = '0;
    end
    t = 1;
    for (int s = 0; s < L; s++) begin
      span = N >> (s + 1);
      for (int k = 0; k < N / 2; k++) begin
        j = k % span;
        g = k / span;
        a = g * 2 * span + j;
        exp_rd[t]    = 1;
        exp_a[t]     = L'(a);
        exp_b[t]     = L'(a + span);
        exp_tw[t]    = (L-1)'(j * (1 << s));
        exp_stg[t]   = L'(s);
        exp_bfv[t+RD] = 1;
        exp_wr[t+P]  = 1;
        exp_wa[t+P]  = L'(a);
        exp_wb[t+P]  = L'(a + span);
        t++;
      end
      t += P;
    end
`ifdef FFT_SEQ_UNLOAD_EN
    for (int i = 0; i < N; i++) begin
      r = 0;
      for (int b = 0; b < L; b++)
        if (((i >> b) & 1) == 1) r += 1 << (L - 1 - b);
      exp_rd[t]  = 1;
      exp_a[t]   = L'(r);
      exp_stg[t] = L'(L - 1);
      t++;
    end
`endif
    done_cyc = t;
    exp_done[t] = 1;
    for (int c = 1; c < t; c++) exp_busy[c] = 1;
  endtask

  // mode: 0 clk_en high, 1 toggling, 2 random. fault: cycle with bf_ovalid withheld.
  task automatic run(input int mode, input int fault, input bit noise,
                     input int abort_at);
    int c, guard;
    logic err_exp;
    start = 1; clk_en = 1; bf_ovalid = 0;
    @(posedge clk); #1;
    start = 0;
    c = 1; guard = 0; err_exp = 0;
    while (1) begin
      vectors++;
      if (rd_en !== exp_rd[c]) begin miscompares++;
        $display("FAIL rd_en c%0d got %b want %b", c, rd_en, exp_rd[c]); end
      vectors++;
      if (rd_addr_a !== exp_a[c]) begin miscompares++;
        $display("FAIL rd_addr_a c%0d got %0d want %0d", c, rd_addr_a, exp_a[c]); end
      vectors++;
      if (rd_addr_b !== exp_b[c]) begin miscompares++;
        $display("FAIL rd_addr_b c%0d got %0d want %0d", c, rd_addr_b, exp_b[c]); end
      vectors++;
      if (tw_addr !== exp_tw[c]) begin miscompares++;
        $display("FAIL tw_addr c%0d got %0d want %0d", c, tw_addr, exp_tw[c]); end
      vectors++;
      if (bf_valid !== exp_bfv[c]) begin miscompares++;
        $display("FAIL bf_valid c%0d got %b want %b", c, bf_valid, exp_bfv[c]); end
      vectors++;
      if (wr_en !== exp_wr[c]) begin miscompares++;
        $display("FAIL wr_en c%0d got %b want %b", c, wr_en, exp_wr[c]); end
      vectors++;
      if (wr_addr_a !== exp_wa[c]) begin miscompares++;
        $display("FAIL wr_addr_a c%0d got %0d want %0d", c, wr_addr_a, exp_wa[c]); end
      vectors++;
      if (wr_addr_b !== exp_wb[c]) begin miscompares++;
        $display("FAIL wr_addr_b c%0d got %0d want %0d", c, wr_addr_b, exp_wb[c]); end
      vectors++;
      if (busy !== exp_busy[c]) begin miscompares++;
        $display("FAIL busy c%0d got %b want %b", c, busy, exp_busy[c]); end
      vectors++;
      if (done !== exp_done[c]) begin miscompares++;
        $display("FAIL done c%0d got %b want %b", c, done, exp_done[c]); end
      vectors++;
      if (err !== err_exp) begin miscompares++;
        $display("FAIL err c%0d got %b want %b", c, err, err_exp); end
      if (exp_rd[c]) begin
        vectors++;
        if (stage !== exp_stg[c]) begin miscompares++;
          $display("FAIL stage c%0d got %0d want %0d", c, stage, exp_stg[c]); end
      end
      if (c == abort_at) begin
        rst_n = 0;
        #1;
        vectors++;
        if ({rd_en, busy, bf_valid, wr_en, done, err} !== 6'b0) begin
          miscompares++;
          $display("FAIL async_reset_flags got %b want 000000",
                   {rd_en, busy, bf_valid, wr_en, done, err});
        end
        vectors++;
        if ({stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== '0) begin
          miscompares++;
          $display("FAIL async_reset_buses got %h want 0",
                   {stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
        end
        start = 0; bf_ovalid = 0;
        @(negedge clk);
        rst_n = 1; clk_en = 1;
        @(posedge clk); #1;
        return;
      end
      if (c == done_cyc + 1) break;
      bf_ovalid = exp_wr[c] & (c != fault);
      if (mode == 0) clk_en = 1;
      else if (mode == 1) clk_en = ~clk_en;
      else clk_en = ($urandom % 4) != 0;
      start = noise && (c < done_cyc) && (($urandom % 3) == 0);
      guard++;
      @(posedge clk); #1;
      if (clk_en) begin
        if (bf_ovalid != exp_wr[c]) err_exp = 1;
        c++;
      end
      if (guard > 1000) begin
        vectors++; miscompares++;
        $display("FAIL timeout c%0d got no progress want done by c%0d", c, done_cyc);
        break;
      end
    end
    start = 0; clk_en = 1; bf_ovalid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; clk_en = 0; start = 0; bf_ovalid = 0;
    #12;
    vectors++;
    if ({busy, done, rd_en, bf_valid, wr_en, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 000000",
               {busy, done, rd_en, bf_valid, wr_en, err});
    end
    vectors++;
    if ({stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_buses got %h want 0",
               {stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
    end
    @(negedge clk);
    rst_n = 1; clk_en = 1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, rd_en} !== 2'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset got %b want 00", {busy, rd_en});
    end
  endtask

  task automatic test_nominal();
    run(0, -1, 0, -1);
  endtask

  task automatic test_clk_en_toggle();
    clk_en = 1;
    run(1, -1, 0, -1);
  endtask

  task automatic test_start_no_clk_en();
    clk_en = 0; start = 1;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL start_gated busy got %b want 0", busy);
      end
    end
    start = 0; clk_en = 1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, rd_en} !== 2'b0) begin
      miscompares++;
      $display("FAIL start_gated_after got %b want 00", {busy, rd_en});
    end
  endtask

  task automatic test_reset_mid();
    run(0, -1, 0, 10);
    run(0, -1, 0, -1);
  endtask

  task automatic test_err();
    int f;
    do f = $urandom_range(1, done_cyc - 1); while (!exp_wr[f]);
    run(2, f, 1, -1);
    run(0, -1, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) run(2, -1, 1, -1);
  endtask

  initial begin
    build_model();
    test_reset();
    test_nominal();
    test_clk_en_toggle();
    test_start_no_clk_en();
    test_reset_mid();
    test_err();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
